load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter WORD_ADDR_W, default 20, giving the number of word-index bits driven to data memory.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port req_valid  input  1  pipeline memory request present.
REQ-005 The block SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-006 The block SHALL have port req_op  input  3  operation code: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
REQ-007 The block SHALL have port req_addr  input  32  byte address.
REQ-008 The block SHALL have port req_wdata  input  32  store data, right-justified for SB/SH.
REQ-009 The block SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port resp_rdata  output  32  extended load result, valid with resp_valid.
REQ-011 The block SHALL have port misalign  output  1  alignment fault, valid with resp_valid.
REQ-012 The block SHALL have port mem_address  output  32  word index to data memory.
REQ-013 The block SHALL have port mem_read  output  1  data memory read strobe.
REQ-014 The block SHALL have port mem_write  output  1  data memory write strobe.
REQ-015 The block SHALL have port mem_wdata  output  32  full word to write.
REQ-016 The block SHALL have port mem_rdata  input  32  data memory read word, valid the cycle after a mem_read cycle.

Function
REQ-017 The FSM SHALL have states IDLE, RD, EXT, WR, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, latching op, addr and wdata.
REQ-019 Misalignment SHALL be LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0; byte ops are never misaligned.
REQ-020 On acceptance the next state SHALL be: RESP with misalign latched to 1 if misaligned (no memory strobe ever issued); WR for SW; RD for all loads, SB and SH.
REQ-021 mem_read SHALL be 1 exactly in RD; mem_write SHALL be 1 exactly in WR; both are Moore outputs of the state register and are never 1 together.
REQ-022 mem_address SHALL be {zeros, addr[WORD_ADDR_W+1:2]}; byte address bits above WORD_ADDR_W+1 are discarded, so word indices wrap modulo 2^WORD_ADDR_W.
REQ-023 RD SHALL always go to EXT; in EXT, mem_rdata is sampled once.
REQ-024 Byte lanes SHALL be big-endian: offset 0 = bits[31:24], 3 = bits[7:0]; halfword addr[1]=0 = bits[31:16], addr[1]=1 = bits[15:0].
REQ-025 In EXT for loads, resp_rdata SHALL be registered as: LW the word; LB/LH the selected lane sign-extended; LBU/LHU zero-extended; next state RESP.
REQ-026 In EXT for SB/SH, mem_wdata SHALL be registered as mem_rdata with only the selected lane replaced by req_wdata[7:0] or [15:0]; next state WR.
REQ-027 For SW, mem_wdata SHALL be registered with req_wdata at acceptance.
REQ-028 WR SHALL always go to RESP; RESP SHALL assert resp_valid for exactly one cycle and go to IDLE.
REQ-029 resp_rdata SHALL be 0 for store and misaligned responses; misalign SHALL be 0 for aligned responses.
REQ-030 Latency, acceptance edge to resp_valid cycle: misaligned 1, SW 2, loads 3, SB/SH 4 cycles.
REQ-031 resp_valid has no backpressure; a new request is accepted no earlier than the edge ending RESP, via IDLE (one idle cycle minimum between operations).

Reset
REQ-032 On a rising edge with rst=1 the block SHALL enter IDLE and clear resp_valid, resp_rdata, misalign, mem_read, mem_write, mem_wdata and mem_address to 0, taking priority over any request.
REQ-033 rst during RD, EXT or WR SHALL abort the operation with no further strobe after the reset edge; any partially merged SB/SH word SHALL NOT be written.

Verification
REQ-034 Preload word 5 = 0x8234_56F0; LB addr 0x14 -> mem_read in RD, resp_valid 3 cycles after accept, resp_rdata 0xFFFF_FF82.
REQ-035 Same word; LHU addr 0x16 -> resp_rdata 0x0000_56F0; LH addr 0x16 -> 0x0000_56F0; LBU addr 0x17 -> 0x0000_00F0.
REQ-036 Word 5 = 0x1122_3344; SB addr 0x15 wdata 0xAB -> RD, EXT, one mem_write cycle with mem_wdata 0x11AB_3344, resp_valid 4 cycles after accept.
REQ-037 LW addr 0x0000_0006 -> resp_valid next cycle with misalign=1, resp_rdata 0, mem_read and mem_write never asserted.
REQ-038 SW addr 0x0040_0008, WORD_ADDR_W=20 -> mem_address 0x0000_0002 (wrap), mem_write in WR only, resp_valid 2 cycles after accept.
REQ-039 SH addr 0x12 issued, rst=1 in EXT -> IDLE next cycle, all outputs 0, no mem_write pulse observed.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: big-endian byte/halfword/word access to a word-wide data memory,
// with read-modify-write for sub-word stores and alignment fault detection.
module load_store_unit #(
  parameter int WORD_ADDR_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [2:0] {IDLE, RD, EXT, WR, RESP} state_t;

  state_t      state;
  logic [2:0]  op;
  logic [1:0]  off;
  logic [15:0] wdata;

  // Byte address bits above the word index are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(req_addr >> (WORD_ADDR_W + 2));

  function automatic logic is_misaligned(input logic [2:0] o, input logic [1:0] a);
    case (o)
      OP_LW, OP_SW:         return a != 2'b00;
      OP_LH, OP_LHU, OP_SH: return a[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] o, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [31:0]        bsh;
    logic [31:0]        hsh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    bsh = w >> {~a, 3'b000};
    hsh = w >> {~a[1], 4'b0000};
    b   = bsh[7:0];
    h   = hsh[15:0];
    case (o)
      OP_LB:   return 32'(b);
      OP_LH:   return 32'(h);
      OP_LW:   return w;
      OP_LBU:  return {24'b0, bsh[7:0]};
      OP_LHU:  return {16'b0, hsh[15:0]};
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] o, input logic [1:0] a,
                                              input logic [31:0] w, input logic [15:0] d);
    logic [31:0] mask;
    logic [31:0] ins;
    if (o == OP_SB) begin
      mask = 32'h0000_00FF << {~a, 3'b000};
      ins  = {24'b0, d[7:0]} << {~a, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {~a[1], 4'b0000};
      ins  = {16'b0, d} << {~a[1], 4'b0000};
    end
    return (w & ~mask) | ins;
  endfunction

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op          <= OP_LB;
      off         <= 2'b00;
      wdata       <= 16'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'b0;
      misalign    <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= 32'b0;
      mem_address <= 32'b0;
    end else begin
      resp_valid <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          op          <= req_op;
          off         <= req_addr[1:0];
          wdata       <= req_wdata[15:0];
          mem_address <= {{(32 - WORD_ADDR_W){1'b0}}, req_addr[WORD_ADDR_W+1:2]};
          resp_rdata  <= 32'b0;
          misalign    <= 1'b0;
          if (is_misaligned(req_op, req_addr[1:0])) begin
            misalign   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (req_op == OP_SW) begin
            mem_wdata <= req_wdata;
            mem_write <= 1'b1;
            state     <= WR;
          end else begin
            mem_read <= 1'b1;
            state    <= RD;
          end
        end
        RD: state <= EXT;
        // Memory word is valid now; loads finish, sub-word stores merge and write back.
        EXT: begin
          if (op == OP_SB || op == OP_SH) begin
            mem_wdata <= store_merge(op, off, mem_rdata, wdata);
            mem_write <= 1'b1;
            state     <= WR;
          end else begin
            resp_rdata <= load_extend(op, off, mem_rdata);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit with a word-array memory and a reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        clr = 1'b0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_ADDR_W(20)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign(misalign),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous memory: read data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (mem_write) begin
      mem[mem_address[7:0]] <= mem_wdata;
    end
    if (mem_read) mem_rdata <= mem[mem_address[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Reference model: result of one operation from the architectural rules.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output logic mis, output int lat, output logic [31:0] rd,
                       output logic [31:0] newword, output logic [31:0] widx);
    logic [31:0] word, byt, half;
    int bs, hs;
    widx = (a / 4) % (32'd1 << 20);
    word = ref_mem[widx % 256];
    bs   = 24 - 8 * int'(a % 4);
    hs   = ((a / 2) % 2 == 1) ? 0 : 16;
    byt  = (word >> bs) & 32'hFF;
    half = (word >> hs) & 32'hFFFF;
    mis  = ((op == 2 || op == 7) && (a % 4 != 0)) ||
           ((op == 1 || op == 4 || op == 6) && (a % 2 != 0));
    rd = 32'd0;
    newword = word;
    if (mis) lat = 1;
    else if (op == 7) begin lat = 2; newword = wd; end
    else if (op >= 5) begin
      lat = 4;
      if (op == 5) newword = (word & ~(32'hFF << bs)) | ((wd & 32'hFF) << bs);
      else         newword = (word & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
    end else begin
      lat = 3;
      case (op)
        3'd0: rd = (byt >= 128) ? byt + 32'hFFFF_FF00 : byt;
        3'd1: rd = (half >= 32768) ? half + 32'hFFFF_0000 : half;
        3'd2: rd = word;
        3'd3: rd = byt;
        default: rd = half;
      endcase
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] got_rd, output logic [31:0] got_wd);
    logic mis; int lat; logic [31:0] erd, ewd, widx;
    int cycles, nrd, nwr;
    logic got;
    model(op, a, wd, mis, lat, erd, ewd, widx);
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cycles = 0; nrd = 0; nwr = 0; got = 1'b0; got_rd = 32'd0; got_wd = 32'd0;
    while (!got && cycles < 12) begin
      @(negedge clk);
      cycles++;
      if (mem_read && mem_write) check("strobe_overlap", 32'd1, 32'd0);
      if (mem_read) begin
        nrd++;
        check("rd_addr", mem_address, widx);
        check("rd_cycle", 32'(cycles), 32'd1);
      end
      if (mem_write) begin
        nwr++;
        got_wd = mem_wdata;
        check("wr_addr", mem_address, widx);
      end
      if (resp_valid) begin
        got = 1'b1;
        got_rd = resp_rdata;
        check("latency", 32'(cycles), 32'(lat));
        check("rdata", resp_rdata, erd);
        check("misalign", 32'(misalign), 32'(mis));
        check("ready_busy", 32'(req_ready), 32'd0);
      end
    end
    check("resp_seen", 32'(got), 32'd1);
    check("n_read", 32'(nrd), (!mis && op != 3'd7) ? 32'd1 : 32'd0);
    check("n_write", 32'(nwr), (!mis && op >= 3'd5) ? 32'd1 : 32'd0);
    if (!mis && op >= 3'd5) begin
      check("wdata", got_wd, ewd);
      ref_mem[widx % 256] = ewd;
    end
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] r, w, a;
    logic [2:0]  op;
    int nwr;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    preload(8'd5, 32'h8234_56F0);
    do_op(3'd0, 32'h14, 32'd0, r, w); check("lb_0x14", r, 32'hFFFF_FF82);
    do_op(3'd4, 32'h16, 32'd0, r, w); check("lhu_0x16", r, 32'h0000_56F0);
    do_op(3'd1, 32'h16, 32'd0, r, w); check("lh_0x16", r, 32'h0000_56F0);
    do_op(3'd3, 32'h17, 32'd0, r, w); check("lbu_0x17", r, 32'h0000_00F0);
    do_op(3'd1, 32'h14, 32'd0, r, w); check("lh_0x14", r, 32'hFFFF_8234);
    preload(8'd5, 32'h1122_3344);
    do_op(3'd5, 32'h15, 32'h0000_00AB, r, w); check("sb_merge", w, 32'h11AB_3344);
    do_op(3'd2, 32'h14, 32'd0, r, w); check("lw_after_sb", r, 32'h11AB_3344);
    do_op(3'd2, 32'h6, 32'd0, r, w); check("lw_mis_rdata", r, 32'd0);
    do_op(3'd7, 32'h0040_0008, 32'hDEAD_BEEF, r, w); check("sw_wrap_data", w, 32'hDEAD_BEEF);
    do_op(3'd2, 32'h8, 32'd0, r, w); check("lw_wrapped", r, 32'hDEAD_BEEF);

    // Reset during EXT of a halfword store must suppress the write-back.
    preload(8'd4, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd6; req_addr = 32'h12; req_wdata = 32'h0000_1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_outputs", {29'd0, resp_valid, mem_read, mem_write}, 32'd0);
    check("abort_rdata", resp_rdata, 32'd0);
    check("abort_wdata", mem_wdata, 32'd0);
    check("abort_address", mem_address, 32'd0);
    nwr = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_write || resp_valid) nwr++;
    end
    check("abort_no_write", 32'(nwr), 32'd0);
    do_op(3'd2, 32'h10, 32'd0, r, w); check("abort_mem_kept", r, 32'hCAFE_F00D);

    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_003F);
      do_op(op, a, $urandom, r, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
